// File: rtl/uparc_bus_arbiter_pkg.sv
// rtl/uparc_bus_arbiter_pkg.sv - shared types and helpers for the system-bus arbiter
// Purpose: bus command encodings, port identifiers and the grant decision helper.
// Ports: none (package).
package uparc_bus_arbiter_pkg;

  typedef logic [1:0] bus_cmd_t;

  localparam bus_cmd_t UPARC_BUS_CMD_NONE  = 2'b00;
  localparam bus_cmd_t UPARC_BUS_CMD_READ  = 2'b01;
  localparam bus_cmd_t UPARC_BUS_CMD_WRITE = 2'b10;

  typedef enum logic {
    PORT_IFU = 1'b0,
    PORT_LSU = 1'b1
  } arb_port_t;

  // Winner among registered pending entries. On a tie, fixed-priority mode
  // always picks the LSU; round-robin mode picks the port not granted last.
  function automatic arb_port_t arb_pick(input logic ifu_p, input logic lsu_p,
                                         input logic prio_lsu, input arb_port_t last);
    arb_port_t win;
    if (ifu_p && lsu_p) begin
      if (prio_lsu) win = PORT_LSU;
      else          win = (last == PORT_LSU) ? PORT_IFU : PORT_LSU;
    end else if (lsu_p) begin
      win = PORT_LSU;
    end else begin
      win = PORT_IFU;
    end
    return win;
  endfunction

endpackage

// File: rtl/uparc_arb_req_latch.sv
// rtl/uparc_arb_req_latch.sv - per-port pending request register with capture logic
// Purpose: holds one captured request until the arbiter grants it.
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   req              request pulse (already qualified by the caller)
//   req_cmd/addr/be/wdata  request fields sampled with req
//   blocked          port owns a transaction that is not retiring this cycle
//   take             arbiter consumed the entry this cycle
//   pending          entry valid
//   cmd/addr/be/wdata  captured request fields
module uparc_arb_req_latch
  import uparc_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req,
  input  bus_cmd_t          req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              blocked,
  input  logic              take,
  output logic              pending,
  output bus_cmd_t          cmd,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata
);

  logic accept;

  // A pulse arriving while the port is busy is dropped, not queued.
  assign accept = req & ~pending & ~blocked;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pending <= 1'b0;
      cmd     <= UPARC_BUS_CMD_NONE;
      addr    <= '0;
      be      <= '0;
      wdata   <= '0;
    end else if (accept) begin
      pending <= 1'b1;
      cmd     <= req_cmd;
      addr    <= req_addr;
      be      <= req_be;
      wdata   <= req_wdata;
    end else if (take) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/uparc_bus_arbiter.sv
// rtl/uparc_bus_arbiter.sv - IFU/LSU arbiter for the single CPU system-bus master port
// Purpose: captures fetch and load/store request pulses, grants one at a time and runs
//   a command phase then a response phase on the bus, returning data/errors to the owner.
// Ports:
//   clk, nrst                       clock, asynchronous active-low reset
//   i_ifu_addr/i_ifu_rd             fetch request; o_ifu_busy/o_ifu_data/o_ifu_err_bus/o_ifu_err_algn
//   i_lsu_addr/rd/wr/be/wdata       load/store request; o_lsu_busy/o_lsu_rdata/o_lsu_err_bus
//   o_bus_cmd/addr/be/wdata         bus command, held until i_bus_ready
//   i_bus_ready                     command accepted
//   i_bus_rvalid/i_bus_rdata/i_bus_err  response
module uparc_bus_arbiter
  import uparc_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] i_ifu_addr,
  input  logic              i_ifu_rd,
  output logic              o_ifu_busy,
  output logic [DATA_W-1:0] o_ifu_data,
  output logic              o_ifu_err_bus,
  output logic              o_ifu_err_algn,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic              i_lsu_rd,
  input  logic              i_lsu_wr,
  input  logic [3:0]        i_lsu_be,
  input  logic [DATA_W-1:0] i_lsu_wdata,
  output logic              o_lsu_busy,
  output logic [DATA_W-1:0] o_lsu_rdata,
  output logic              o_lsu_err_bus,
  output logic [1:0]        o_bus_cmd,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [3:0]        o_bus_be,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ready,
  input  logic              i_bus_rvalid,
  input  logic [DATA_W-1:0] i_bus_rdata,
  input  logic              i_bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t    state;
  arb_port_t owner;
  arb_port_t last_grant;
  arb_port_t winner;

  logic              ifu_pending, lsu_pending;
  bus_cmd_t          ifu_pcmd, lsu_pcmd;
  logic [ADDR_W-1:0] ifu_paddr, lsu_paddr;
  logic [3:0]        ifu_pbe, lsu_pbe;
  logic [DATA_W-1:0] ifu_pwdata, lsu_pwdata;
  logic              retire, ifu_blocked, lsu_blocked;
  logic              ifu_aligned, algn_fault, grant_valid, ifu_take, lsu_take;

  // The owner becomes free in its retire cycle so a back-to-back pulse is accepted.
  assign retire      = (state == ST_RESP) & i_bus_rvalid;
  assign ifu_blocked = (state != ST_IDLE) & (owner == PORT_IFU) & ~retire;
  assign lsu_blocked = (state != ST_IDLE) & (owner == PORT_LSU) & ~retire;

  assign ifu_aligned = (i_ifu_addr[1:0] == 2'b00);
  assign algn_fault  = i_ifu_rd & ~ifu_aligned & ~ifu_pending & ~ifu_blocked;

  assign grant_valid = (state == ST_IDLE) & (ifu_pending | lsu_pending);
  assign winner      = arb_pick(ifu_pending, lsu_pending, PRIO_MODE == 1, last_grant);
  assign ifu_take    = grant_valid & (winner == PORT_IFU);
  assign lsu_take    = grant_valid & (winner == PORT_LSU);

  assign o_ifu_busy = i_ifu_rd | ifu_pending | ((state != ST_IDLE) & (owner == PORT_IFU));
  assign o_lsu_busy = i_lsu_rd | i_lsu_wr | lsu_pending | ((state != ST_IDLE) & (owner == PORT_LSU));

  uparc_arb_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ifu_latch (
    .clk       (clk),
    .nrst      (nrst),
    .req       (i_ifu_rd & ifu_aligned),
    .req_cmd   (UPARC_BUS_CMD_READ),
    .req_addr  (i_ifu_addr),
    .req_be    (4'hF),
    .req_wdata ('0),
    .blocked   (ifu_blocked),
    .take      (ifu_take),
    .pending   (ifu_pending),
    .cmd       (ifu_pcmd),
    .addr      (ifu_paddr),
    .be        (ifu_pbe),
    .wdata     (ifu_pwdata)
  );

  // Write wins if both strobes are (illegally) raised together.
  uparc_arb_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lsu_latch (
    .clk       (clk),
    .nrst      (nrst),
    .req       (i_lsu_rd | i_lsu_wr),
    .req_cmd   (i_lsu_wr ? UPARC_BUS_CMD_WRITE : UPARC_BUS_CMD_READ),
    .req_addr  (i_lsu_addr),
    .req_be    (i_lsu_be),
    .req_wdata (i_lsu_wdata),
    .blocked   (lsu_blocked),
    .take      (lsu_take),
    .pending   (lsu_pending),
    .cmd       (lsu_pcmd),
    .addr      (lsu_paddr),
    .be        (lsu_pbe),
    .wdata     (lsu_pwdata)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= ST_IDLE;
      owner          <= PORT_IFU;
      last_grant     <= PORT_LSU;
      o_bus_cmd      <= UPARC_BUS_CMD_NONE;
      o_bus_addr     <= '0;
      o_bus_be       <= '0;
      o_bus_wdata    <= '0;
      o_ifu_data     <= '0;
      o_lsu_rdata    <= '0;
      o_ifu_err_bus  <= 1'b0;
      o_lsu_err_bus  <= 1'b0;
      o_ifu_err_algn <= 1'b0;
    end else begin
      o_ifu_err_bus  <= 1'b0;
      o_lsu_err_bus  <= 1'b0;
      o_ifu_err_algn <= algn_fault;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner      <= winner;
            last_grant <= winner;
            state      <= ST_CMD;
            if (winner == PORT_LSU) begin
              o_bus_cmd   <= lsu_pcmd;
              o_bus_addr  <= lsu_paddr;
              o_bus_be    <= lsu_pbe;
              o_bus_wdata <= lsu_pwdata;
            end else begin
              o_bus_cmd   <= ifu_pcmd;
              o_bus_addr  <= ifu_paddr;
              o_bus_be    <= ifu_pbe;
              o_bus_wdata <= ifu_pwdata;
            end
          end
        end
        ST_CMD: begin
          if (i_bus_ready) begin
            o_bus_cmd <= UPARC_BUS_CMD_NONE;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_bus_rvalid) begin
            if (owner == PORT_IFU) begin
              o_ifu_data    <= i_bus_err ? '0 : i_bus_rdata;
              o_ifu_err_bus <= i_bus_err;
            end else begin
              o_lsu_rdata   <= i_bus_err ? '0 : i_bus_rdata;
              o_lsu_err_bus <= i_bus_err;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uparc_bus_arbiter.sv
// tb/tb_uparc_bus_arbiter.sv - self-checking bench for uparc_bus_arbiter (round-robin and LSU-priority builds)
module tb_uparc_bus_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_rd = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic        lsu_rd = 1'b0;
  logic        lsu_wr = 1'b0;
  logic [3:0]  lsu_be = '0;
  logic [31:0] lsu_wdata = '0;
  logic        bus_ready = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  // Index 0: PRIO_MODE=0 build, index 1: PRIO_MODE=1 build; both share all inputs.
  logic        ifu_busy [2];
  logic [31:0] ifu_data [2];
  logic        ifu_err_bus [2];
  logic        ifu_err_algn [2];
  logic        lsu_busy [2];
  logic [31:0] lsu_rdata [2];
  logic        lsu_err_bus [2];
  logic [1:0]  bus_cmd [2];
  logic [31:0] bus_addr [2];
  logic [3:0]  bus_be [2];
  logic [31:0] bus_wdata [2];

  int tests = 0;
  int fails = 0;

  // Reference model state (spec-level): last granted port (0=IFU, 1=LSU) and each port's data reg.
  int          m_last = 1;
  logic [31:0] m_ifu = '0;
  logic [31:0] m_lsu = '0;

  always #5 clk = ~clk;

  uparc_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) dut0 (
    .clk(clk), .nrst(nrst),
    .i_ifu_addr(ifu_addr), .i_ifu_rd(ifu_rd), .o_ifu_busy(ifu_busy[0]), .o_ifu_data(ifu_data[0]),
    .o_ifu_err_bus(ifu_err_bus[0]), .o_ifu_err_algn(ifu_err_algn[0]),
    .i_lsu_addr(lsu_addr), .i_lsu_rd(lsu_rd), .i_lsu_wr(lsu_wr), .i_lsu_be(lsu_be), .i_lsu_wdata(lsu_wdata),
    .o_lsu_busy(lsu_busy[0]), .o_lsu_rdata(lsu_rdata[0]), .o_lsu_err_bus(lsu_err_bus[0]),
    .o_bus_cmd(bus_cmd[0]), .o_bus_addr(bus_addr[0]), .o_bus_be(bus_be[0]), .o_bus_wdata(bus_wdata[0]),
    .i_bus_ready(bus_ready), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata), .i_bus_err(bus_err)
  );

  uparc_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) dut1 (
    .clk(clk), .nrst(nrst),
    .i_ifu_addr(ifu_addr), .i_ifu_rd(ifu_rd), .o_ifu_busy(ifu_busy[1]), .o_ifu_data(ifu_data[1]),
    .o_ifu_err_bus(ifu_err_bus[1]), .o_ifu_err_algn(ifu_err_algn[1]),
    .i_lsu_addr(lsu_addr), .i_lsu_rd(lsu_rd), .i_lsu_wr(lsu_wr), .i_lsu_be(lsu_be), .i_lsu_wdata(lsu_wdata),
    .o_lsu_busy(lsu_busy[1]), .o_lsu_rdata(lsu_rdata[1]), .o_lsu_err_bus(lsu_err_bus[1]),
    .o_bus_cmd(bus_cmd[1]), .o_bus_addr(bus_addr[1]), .o_bus_be(bus_be[1]), .o_bus_wdata(bus_wdata[1]),
    .i_bus_ready(bus_ready), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata), .i_bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    ifu_rd = 1'b0; lsu_rd = 1'b0; lsu_wr = 1'b0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    tick();
    m_last = 1; m_ifu = '0; m_lsu = '0;
  endtask

  // Waits for a command, holds ready low rlat cycles checking stability, accepts it,
  // waits vlat cycles, then returns one response.
  task automatic serve(input int d, input int rlat, input int vlat, input logic [31:0] rd, input logic err,
                       output logic [1:0] c, output logic [31:0] a, output logic [3:0] b, output logic [31:0] w);
    int n;
    n = 0;
    while (bus_cmd[d] == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check("cmd_wait_budget", n < 20, 1'b1);
    c = bus_cmd[d]; a = bus_addr[d]; b = bus_be[d]; w = bus_wdata[d];
    for (int i = 0; i < rlat; i++) begin
      tick();
      check("cmd_stable", {bus_cmd[d], bus_addr[d], bus_be[d], bus_wdata[d]}, {c, a, b, w});
    end
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    check("cmd_cleared", bus_cmd[d], 2'b00);
    for (int i = 0; i < vlat; i++) tick();
    bus_rvalid = 1'b1; bus_rdata = rd; bus_err = err;
    tick();
    bus_rvalid = 1'b0; bus_err = 1'b0;
  endtask

  // One round: pulse the chosen ports together, serve everything in the order the
  // arbitration rules dictate, and check fields, data regs, error pulses and busy.
  task automatic run_round(input int d, input logic di, input logic dl, input logic wr,
                           input logic [31:0] ia, input logic [31:0] la, input logic [3:0] be,
                           input logic [31:0] wd, input int rlat, input int vlat, input int err_sel);
    int order[$];
    int first;
    logic [1:0] c; logic [31:0] a, w, rd; logic [3:0] b; logic e;
    if (di && dl) begin
      first = (d == 1) ? 1 : (m_last == 1 ? 0 : 1);
      order.push_back(first);
      order.push_back(1 - first);
    end else if (di) begin
      order.push_back(0);
    end else begin
      order.push_back(1);
    end
    ifu_rd = di; ifu_addr = ia;
    lsu_rd = dl & ~wr; lsu_wr = dl & wr; lsu_addr = la; lsu_be = be; lsu_wdata = wd;
    #1;
    check("pulse_busy", {ifu_busy[d], lsu_busy[d]}, {di, dl});
    tick();
    ifu_rd = 1'b0; lsu_rd = 1'b0; lsu_wr = 1'b0;
    foreach (order[k]) begin
      rd = $urandom;
      e = (err_sel == 2) ? ($urandom_range(0, 3) == 0) : (err_sel == 1);
      serve(d, rlat, vlat, rd, e, c, a, b, w);
      m_last = order[k];
      if (order[k] == 0) begin
        check("ifu_fields", {c, a, b, w}, {2'b01, ia, 4'hF, 32'h0});
        m_ifu = e ? 32'h0 : rd;
        check("ifu_idle_after", ifu_busy[d], 1'b0);
      end else begin
        check("lsu_fields", {c, a, b, w}, {(wr ? 2'b10 : 2'b01), la, be, wd});
        m_lsu = e ? 32'h0 : rd;
        check("lsu_idle_after", lsu_busy[d], 1'b0);
      end
      check("ifu_data", ifu_data[d], m_ifu);
      check("lsu_rdata", lsu_rdata[d], m_lsu);
      check("err_pulses", {ifu_err_bus[d], lsu_err_bus[d]}, {order[k] == 0 && e, order[k] == 1 && e});
    end
  endtask

  initial begin
    logic [1:0] c; logic [31:0] a, w, rd; logic [3:0] b;
    int pat, n;

    do_reset();
    for (int d = 0; d < 2; d++) begin
      check("reset_bus", {bus_cmd[d], bus_addr[d], bus_be[d], bus_wdata[d]}, 72'h0);
      check("reset_data", {ifu_data[d], lsu_rdata[d]}, 72'h0);
      check("reset_flags", {ifu_busy[d], lsu_busy[d], ifu_err_bus[d], lsu_err_bus[d], ifu_err_algn[d]}, 5'b0);
    end

    // Single fetch: issue two cycles after the pulse, five busy cycles.
    ifu_rd = 1'b1; ifu_addr = 32'h100;
    #1 check("t1_busy_c0", ifu_busy[0], 1'b1);
    tick();
    ifu_rd = 1'b0;
    #1 check("t1_c1", {ifu_busy[0], bus_cmd[0]}, {1'b1, 2'b00});
    tick();
    check("t1_c2_cmd", {ifu_busy[0], bus_cmd[0], bus_addr[0], bus_be[0]}, {1'b1, 2'b01, 32'h100, 4'hF});
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    check("t1_c3", {ifu_busy[0], bus_cmd[0]}, {1'b1, 2'b00});
    tick();
    bus_rvalid = 1'b1; bus_rdata = 32'h2402_0001;
    #1 check("t1_c4_busy", ifu_busy[0], 1'b1);
    tick();
    bus_rvalid = 1'b0;
    check("t1_c5", {ifu_busy[0], ifu_data[0], ifu_err_bus[0]}, {1'b0, 32'h2402_0001, 1'b0});

    // Round-robin ties from reset: IFU first, then alternation.
    do_reset();
    for (int r = 0; r < 3; r++)
      run_round(0, 1'b1, 1'b1, r[0], 32'h1000 + 32'(r) * 4, 32'h8000 + 32'(r) * 4, 4'hF, $urandom, 0, 1, 0);

    // Randomized rounds on the round-robin build.
    for (int r = 0; r < 15; r++) begin
      pat = $urandom_range(1, 3);
      run_round(0, pat[0], pat[1], $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom,
                4'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 2);
    end

    // Store held off by the bus for 4 cycles, answered with an error.
    run_round(0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h2000, 4'b0011, 32'hDEAD_BEEF, 4, 0, 1);
    tick();
    check("t4_err_once", lsu_err_bus[0], 1'b0);

    // Misaligned fetch: alignment error pulse only, no bus traffic.
    ifu_rd = 1'b1; ifu_addr = 32'h102;
    #1 check("t5_busy_pulse", ifu_busy[0], 1'b1);
    tick();
    ifu_rd = 1'b0;
    #1 check("t5_algn", {ifu_err_algn[0], ifu_busy[0], bus_cmd[0]}, {1'b1, 1'b0, 2'b00});
    tick();
    check("t5_algn_once", {ifu_err_algn[0], bus_cmd[0]}, {1'b0, 2'b00});
    tick(); tick();
    check("t5_no_cmd", bus_cmd[0], 2'b00);

    // Reset during the response phase; a late response must be ignored.
    lsu_rd = 1'b1; lsu_addr = 32'h3000; lsu_be = 4'hF;
    tick();
    lsu_rd = 1'b0;
    n = 0;
    while (bus_cmd[0] == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check("t6_cmd_budget", n < 20, 1'b1);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    nrst = 1'b0;
    #1;
    check("t6_reset_bus", {bus_cmd[0], bus_addr[0], bus_be[0]}, 72'h0);
    check("t6_reset_state", {lsu_busy[0], lsu_rdata[0], ifu_data[0]}, 72'h0);
    tick();
    nrst = 1'b1;
    bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'hA5A5_5A5A;
    tick();
    bus_rvalid = 1'b0; bus_err = 1'b0;
    check("t6_late_resp", {lsu_err_bus[0], lsu_busy[0], lsu_rdata[0], bus_cmd[0]}, 72'h0);
    m_last = 1; m_ifu = '0; m_lsu = '0;

    // LSU priority build: continuous LSU pulses starve the IFU until they stop.
    do_reset();
    ifu_rd = 1'b1; ifu_addr = 32'h400;
    lsu_rd = 1'b1; lsu_addr = 32'h5000; lsu_be = 4'hF;
    tick();
    ifu_rd = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) lsu_rd = 1'b0;
      rd = $urandom;
      serve(1, 0, $urandom_range(0, 2), rd, 1'b0, c, a, b, w);
      if (k < 4) begin
        check("t3_lsu_first", {c, a}, {2'b01, 32'h5000});
        check("t3_lsu_data", lsu_rdata[1], rd);
        check("t3_ifu_waiting", ifu_busy[1], 1'b1);
      end else begin
        check("t3_ifu_last", {c, a, b}, {2'b01, 32'h400, 4'hF});
        check("t3_ifu_data", ifu_data[1], rd);
      end
    end

    // Randomized rounds on the LSU-priority build.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      pat = $urandom_range(1, 3);
      run_round(1, pat[0], pat[1], $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom,
                4'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
